atm_button_debouncer: RTL

- Consumes the 100 Hz single-cycle tick from the slow-clock divider and cleans the ATM front-panel pushbuttons.
- Per button: synchronises, debounces by consecutive tick samples and tracks the stable level.
- Produces one-cycle press/release pulses with optional hold auto-repeat, plus an encoded key event for the ATM control FSM downstream.
- All logic runs on the board clock; tick_in is only a sample enable, never a clock.

---
 rtl/atm_button_debouncer.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/atm_button_debouncer.sv
// ---------------------------------------------------------------------------
// atm_button_debouncer
//
// Cleans the ATM front-panel pushbuttons. Each raw input is brought into the
// board clock domain with a two-flop synchroniser, then debounced by counting
// consecutive 100 Hz tick samples that disagree with the current stable level.
// Accepted edges produce one-cycle press/release pulses; a stably held button
// can additionally auto-repeat its press pulse. The lowest-numbered press of a
// cycle is encoded into key_valid/key_code for the downstream control FSM.
//
// tick_in is purely a sample enable; every register runs on clk_in.
// ---------------------------------------------------------------------------
module atm_button_debouncer #(
    parameter  int NUM_BTN        = 5,   // 1..8
    parameter  int STABLE_SAMPLES = 4,   // 1..15
    parameter  int REPEAT_DELAY   = 50,  // 0 disables auto-repeat
    parameter  int REPEAT_RATE    = 10,  // 1..255
    localparam int CODE_W         = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1
) (
    input  logic               clk_in,
    input  logic               rst,
    input  logic               tick_in,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic               key_valid,
    output logic [CODE_W-1:0]  key_code
);

    // -----------------------------------------------------------------------
    // Local sizing
    // -----------------------------------------------------------------------
    localparam int CNT_W     = 4;
    localparam int RPT_W_RAW = $clog2(REPEAT_DELAY + 1);
    localparam int RPT_W     = (RPT_W_RAW < 1) ? 1 : RPT_W_RAW;

    // Last count value before a level change is accepted.
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_SAMPLES - 1);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [NUM_BTN-1:0] r_sync1;
    logic [NUM_BTN-1:0] r_sync2;
    logic [CNT_W-1:0]   r_stable_cnt [NUM_BTN];
    logic [NUM_BTN-1:0] r_level;
    logic [RPT_W-1:0]   r_rpt_cnt    [NUM_BTN];
    logic [NUM_BTN-1:0] r_press;
    logic [NUM_BTN-1:0] r_release;
    logic               r_key_valid;
    logic [CODE_W-1:0]  r_key_code;

    // -----------------------------------------------------------------------
    // Next-state wires
    // -----------------------------------------------------------------------
    logic [CNT_W-1:0]   w_stable_cnt_nxt [NUM_BTN];
    logic [NUM_BTN-1:0] w_level_nxt;
    logic [NUM_BTN-1:0] w_rise;
    logic [NUM_BTN-1:0] w_fall;
    logic [RPT_W-1:0]   w_rpt_nxt        [NUM_BTN];
    logic [NUM_BTN-1:0] w_rpt_fire;
    logic               w_key_any;
    logic [CODE_W-1:0]  w_key_code;

    // -----------------------------------------------------------------------
    // Two-flop synchroniser, free-running (not gated by tick_in)
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            // NOTE: non-blocking assignments give true flop-to-flop behaviour;
            // blocking ones here would collapse the two stages into one.
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    // -----------------------------------------------------------------------
    // Debounce next-state: count ticks that disagree with the stable level
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        w_level_nxt = r_level;
        for (int i = 0; i < NUM_BTN; i++) begin
            w_stable_cnt_nxt[i] = r_stable_cnt[i];
            if (tick_in) begin
                if (r_sync2[i] == r_level[i]) begin
                    // A sample of the old level (bounce) restarts the count.
                    w_stable_cnt_nxt[i] = '0;
                end else if (r_stable_cnt[i] == STABLE_LAST) begin
                    w_level_nxt[i]      = r_sync2[i];
                    w_stable_cnt_nxt[i] = '0;
                end else begin
                    w_stable_cnt_nxt[i] = r_stable_cnt[i] + CNT_W'(1);
                end
            end
        end
        w_rise = w_level_nxt & ~r_level;
        w_fall = r_level & ~w_level_nxt;
    end

    // -----------------------------------------------------------------------
    // Auto-repeat next-state
    // -----------------------------------------------------------------------
    generate
        if (REPEAT_DELAY > 0) begin : g_repeat
            localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_DELAY - 1);
            // A rate at or beyond the delay simply restarts from zero, so the
            // repeat period never exceeds the initial delay.
            localparam logic [RPT_W-1:0] RPT_RELOAD =
                (REPEAT_RATE >= REPEAT_DELAY) ? '0 : RPT_W'(REPEAT_DELAY - REPEAT_RATE);

            // Count ticks while stably pressed; fire and reload on reaching the delay.
            always_comb begin
                w_rpt_fire = '0;
                for (int i = 0; i < NUM_BTN; i++) begin
                    w_rpt_nxt[i] = r_rpt_cnt[i];
                    if (!r_level[i] || w_fall[i]) begin
                        // Released, or releasing this tick: no repeat may follow.
                        w_rpt_nxt[i] = '0;
                    end else if (tick_in) begin
                        if (r_rpt_cnt[i] == RPT_LAST) begin
                            w_rpt_fire[i] = 1'b1;
                            w_rpt_nxt[i]  = RPT_RELOAD;
                        end else begin
                            w_rpt_nxt[i] = r_rpt_cnt[i] + RPT_W'(1);
                        end
                    end
                end
            end
        end else begin : g_no_repeat
            // Auto-repeat disabled: counters stay at zero and never fire.
            always_comb begin
                w_rpt_fire = '0;
                for (int i = 0; i < NUM_BTN; i++) begin
                    w_rpt_nxt[i] = '0;
                end
            end
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Debounce and repeat state registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_level <= '0;
            // NOTE: these per-button counters are control state with a defined
            // power-up value, so they are cleared element by element; a plain
            // data storage array would normally be left without reset.
            for (int i = 0; i < NUM_BTN; i++) begin
                r_stable_cnt[i] <= '0;
                r_rpt_cnt[i]    <= '0;
            end
        end else begin
            r_level <= w_level_nxt;
            for (int i = 0; i < NUM_BTN; i++) begin
                r_stable_cnt[i] <= w_stable_cnt_nxt[i];
                r_rpt_cnt[i]    <= w_rpt_nxt[i];
            end
        end
    end

    // -----------------------------------------------------------------------
    // One-cycle press/release pulses, registered on the level-changing edge
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_press   <= '0;
            r_release <= '0;
        end else begin
            r_press   <= w_rise | w_rpt_fire;
            r_release <= w_fall;
        end
    end

    // -----------------------------------------------------------------------
    // Priority encoder: lowest-numbered press bit wins
    // -----------------------------------------------------------------------
    always_comb begin
        w_key_any  = |r_press;
        w_key_code = '0;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (r_press[i]) begin
                w_key_code = CODE_W'(i);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Key event register; key_code holds while no key is valid
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_key_valid <= 1'b0;
            r_key_code  <= '0;
        end else begin
            r_key_valid <= w_key_any;
            if (w_key_any) begin
                r_key_code <= w_key_code;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign btn_level   = r_level;
    assign btn_press   = r_press;
    assign btn_release = r_release;
    assign key_valid   = r_key_valid;
    assign key_code    = r_key_code;

endmodule
